io_input_capture: RTL and testbench

- Input stage for the MIPS core's IN instruction, sitting upstream of the output/display stage.
- On a CPU input request, stalls the core and waits for the user to press and release a debounced confirm button. It then latches the board switches and returns them zero-extended to 32 bits.
- The captured word is what the core writes back and what the output stage later shows on LEDs/displays.

---
 rtl/io_input_capture.sv | 127 ++++++++++++
 tb/tb_io_input_capture.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_capture.sv
// Input stage for the core's IN instruction: stalls the CPU, waits for a
// debounced press/release of the confirm button, then returns the captured switches.
module io_input_capture #(
  parameter int unsigned SW_WIDTH        = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_req,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                btn_confirm,
  output logic [31:0]         in_data,
  output logic                in_valid,
  output logic                stall,
  output logic                waiting_led
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_PRESS,
    WAIT_RELEASE,
    DONE
  } state_e;

  logic [SW_WIDTH-1:0]  sw_meta_q, sw_sync_q;
  logic                 btn_meta_q, btn_sync_q;
  logic                 btn_db_q, btn_db_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  state_e               state_q;
  logic [31:0]          in_data_q;
  logic                 in_valid_q;
  logic                 waiting_q;
  logic [31:0]          sw_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
    end else begin
      sw_meta_q  <= switches;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= btn_confirm;
      btn_sync_q <= btn_meta_q;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    btn_db_d = btn_db_q;
    cnt_d    = '0;
    if (btn_sync_q != btn_db_q) begin
      if (cnt_q == CNT_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
        btn_db_d = btn_sync_q;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_db_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      btn_db_q <= btn_db_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    sw_ext                = '0;
    sw_ext[SW_WIDTH-1:0]  = sw_sync_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
      waiting_q  <= 1'b0;
    end else begin
      in_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_req) begin
            state_q   <= ARM;
            waiting_q <= 1'b1;
          end
        end
        // Ignore a button already held when the request arrived.
        ARM: begin
          if (!btn_db_q) state_q <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (btn_db_q) begin
            in_data_q <= sw_ext;
            state_q   <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (!btn_db_q) begin
            state_q    <= DONE;
            in_valid_q <= 1'b1;
            waiting_q  <= 1'b0;
          end
        end
        DONE: begin
          if (!in_req) state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          waiting_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_data     = in_data_q;
  assign in_valid    = in_valid_q;
  assign waiting_led = waiting_q;
  assign stall       = waiting_q | ((state_q == IDLE) & in_req);

endmodule

// File: tb/tb_io_input_capture.sv
// Directed bench for io_input_capture with a cycle-level reference model
// checked every cycle, plus hand-computed spot checks.
module tb_io_input_capture;
  localparam int unsigned SW = 16;
  localparam int unsigned DB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_req = 1'b0;
  logic          btn = 1'b0;
  logic [SW-1:0] switches = '0;
  logic [31:0]   in_data;
  logic          in_valid, stall, waiting_led;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  io_input_capture #(
    .SW_WIDTH(SW),
    .DEBOUNCE_CYCLES(DB),
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_req(in_req),
    .switches(switches),
    .btn_confirm(btn),
    .in_data(in_data),
    .in_valid(in_valid),
    .stall(stall),
    .waiting_led(waiting_led)
  );

  // Reference model: phases of the user handshake, inputs delayed two cycles,
  // button level accepted after DB consecutive disagreeing samples.
  typedef enum int {P_IDLE, P_ARM, P_PRESS, P_RELEASE, P_DONE} phase_t;
  phase_t        ph = P_IDLE;
  logic [SW-1:0] sw_d1 = '0, sw_d2 = '0;
  bit            b_d1 = 0, b_d2 = 0;
  bit            m_db = 0;
  int            run = 0;
  logic [31:0]   m_data = '0;
  bit            m_valid = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph = P_IDLE; sw_d1 = '0; sw_d2 = '0; b_d1 = 0; b_d2 = 0;
      m_db = 0; run = 0; m_data = '0; m_valid = 0;
    end else begin
      m_valid = 0;
      case (ph)
        P_IDLE:    if (in_req) ph = P_ARM;
        P_ARM:     if (!m_db) ph = P_PRESS;
        P_PRESS:   if (m_db) begin m_data = 32'(sw_d2); ph = P_RELEASE; end
        P_RELEASE: if (!m_db) begin ph = P_DONE; m_valid = 1; end
        P_DONE:    if (!in_req) ph = P_IDLE;
        default:   ph = P_IDLE;
      endcase
      if (b_d2 != m_db) begin
        run++;
        if (run == DB) begin m_db = b_d2; run = 0; end
      end else begin
        run = 0;
      end
      sw_d2 = sw_d1; sw_d1 = switches;
      b_d2 = b_d1;   b_d1 = btn;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit waiting;
    #3;
    waiting = (ph == P_ARM) || (ph == P_PRESS) || (ph == P_RELEASE);
    check("model_in_data", in_data, m_data);
    check("model_in_valid", 32'(in_valid), 32'(m_valid));
    check("model_waiting_led", 32'(waiting_led), 32'(waiting));
    check("model_stall", 32'(stall), 32'(waiting || (ph == P_IDLE && in_req)));
    if (in_valid) pulses++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #4;
      if (in_valid) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: in_valid got 0 expected 1 within 40 cycles", name);
    end
  endtask

  initial begin
    #200000;
    fails++;
    $display("FAIL global_timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int p0;
    int glitch[6] = '{1, 2, 3, 1, 3, 2};

    cyc(3);
    reset = 1'b0;
    cyc(4);
    check("post_reset_in_data", in_data, 32'h0);
    check("post_reset_stall", 32'(stall), 32'h0);
    check("post_reset_led", 32'(waiting_led), 32'h0);

    // Basic capture
    switches = 16'hA5C3;
    in_req = 1'b1;
    #1 check("stall_on_request_cycle", 32'(stall), 32'h1);
    cyc(3);
    btn = 1'b1;
    cyc(10);
    check("basic_press_data", in_data, 32'h0000A5C3);
    btn = 1'b0;
    wait_valid("basic_valid");
    check("basic_valid_data", in_data, 32'h0000A5C3);
    check("basic_stall_low_at_valid", 32'(stall), 32'h0);
    @(negedge clk) in_req = 1'b0;
    cyc(1);

    // Bounce rejection
    in_req = 1'b1;
    switches = 16'h1234;
    cyc(4);
    foreach (glitch[k]) begin
      btn = 1'b1;
      cyc(glitch[k]);
      btn = 1'b0;
      cyc(2);
    end
    cyc(4);
    check("bounce_data_unchanged", in_data, 32'h0000A5C3);
    check("bounce_still_waiting", 32'(waiting_led), 32'h1);
    btn = 1'b1;
    cyc(8);
    check("bounce_steady_press", in_data, 32'h00001234);
    btn = 1'b0;
    wait_valid("bounce_valid");
    @(negedge clk) in_req = 1'b0;
    cyc(1);

    // Pre-held button
    btn = 1'b1;
    cyc(10);
    switches = 16'hBEEF;
    in_req = 1'b1;
    cyc(10);
    check("preheld_no_capture", in_data, 32'h00001234);
    check("preheld_waiting", 32'(waiting_led), 32'h1);
    btn = 1'b0;
    cyc(10);
    switches = 16'h0F0F;
    btn = 1'b1;
    cyc(10);
    check("preheld_next_press", in_data, 32'h00000F0F);
    btn = 1'b0;
    wait_valid("preheld_valid");

    // Held request after DONE
    p0 = pulses;
    @(negedge clk);
    cyc(20);
    check("held_req_no_extra_pulse", 32'(pulses - p0), 32'h0);
    check("held_req_data", in_data, 32'h00000F0F);
    check("held_req_stall", 32'(stall), 32'h0);
    in_req = 1'b0;
    cyc(1);

    // Fresh capture with late switch change
    in_req = 1'b1;
    switches = 16'h0001;
    p0 = pulses;
    cyc(3);
    btn = 1'b1;
    cyc(8);
    switches = 16'hFFFF;
    cyc(2);
    btn = 1'b0;
    wait_valid("late_switch_valid");
    check("late_switch_data", in_data, 32'h00000001);
    check("fresh_capture_one_pulse", 32'(pulses - p0), 32'h1);
    @(negedge clk) in_req = 1'b0;
    cyc(1);

    // Reset mid-capture
    in_req = 1'b1;
    switches = 16'h5555;
    cyc(3);
    btn = 1'b1;
    cyc(10);
    check("midcap_data", in_data, 32'h00005555);
    in_req = 1'b0;
    cyc(2);
    check("midcap_stall_held", 32'(stall), 32'h1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_data", in_data, 32'h0);
    check("async_reset_valid", 32'(in_valid), 32'h0);
    check("async_reset_stall", 32'(stall), 32'h0);
    check("async_reset_led", 32'(waiting_led), 32'h0);
    cyc(2);
    reset = 1'b0;
    btn = 1'b0;
    p0 = pulses;
    cyc(20);
    check("no_valid_after_reset", 32'(pulses - p0), 32'h0);
    check("idle_after_reset_data", in_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
